hazard_collector: RTL and testbench



---
 rtl/hazard_collector.sv | 124 ++++++++++++
 tb/tb_hazard_collector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_collector.sv
// Collects up to SLOTS-1 normalized hazard boxes per frame from a valid/ready
// stream and holds the completed frame stable until the consumer acknowledges it.
module hazard_collector #(
    parameter int COORD_W = 11,
    parameter int SLOTS   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_keep,
    input  logic                       in_last,
    input  logic [COORD_W-1:0]         in_top,
    input  logic [COORD_W-1:0]         in_left,
    input  logic [COORD_W-1:0]         in_bottom,
    input  logic [COORD_W-1:0]         in_right,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [3:0]                 num_hazards,
    output logic [SLOTS*COORD_W-1:0]   top,
    output logic [SLOTS*COORD_W-1:0]   left,
    output logic [SLOTS*COORD_W-1:0]   bottom,
    output logic [SLOTS*COORD_W-1:0]   right,
    output logic                       overflow
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t state, state_nxt;

    logic [3:0]         count;
    logic               ovf_q;
    logic [COORD_W-1:0] top_q    [SLOTS];
    logic [COORD_W-1:0] left_q   [SLOTS];
    logic [COORD_W-1:0] bottom_q [SLOTS];
    logic [COORD_W-1:0] right_q  [SLOTS];

    logic               accept;
    logic               handoff;
    logic [COORD_W-1:0] n_top, n_left, n_bottom, n_right;

    assign accept  = in_valid && (state == COLLECT);
    assign handoff = (state == HOLD) && frame_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        frame_valid = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (accept && in_last) state_nxt = HOLD;
            end
            HOLD: begin
                frame_valid = 1'b1;
                if (frame_ready) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Boxes may arrive with corners swapped; store them as (min, min, max, max).
    always_comb begin
        n_top    = (in_top  <= in_bottom) ? in_top    : in_bottom;
        n_bottom = (in_top  <= in_bottom) ? in_bottom : in_top;
        n_left   = (in_left <= in_right)  ? in_left   : in_right;
        n_right  = (in_left <= in_right)  ? in_right  : in_left;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf_q <= 1'b0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                top_q[i]    <= '0;
                left_q[i]   <= '0;
                bottom_q[i] <= '0;
                right_q[i]  <= '0;
            end
        end else if (handoff) begin
            count <= '0;
            ovf_q <= 1'b0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                top_q[i]    <= '0;
                left_q[i]   <= '0;
                bottom_q[i] <= '0;
                right_q[i]  <= '0;
            end
        end else if (accept && in_keep) begin
            // The last slot is never written, so it stays zero for the encoder.
            if (count == 4'(SLOTS - 1)) begin
                ovf_q <= 1'b1;
            end else begin
                top_q[count]    <= n_top;
                left_q[count]   <= n_left;
                bottom_q[count] <= n_bottom;
                right_q[count]  <= n_right;
                count           <= count + 4'd1;
            end
        end
    end

    always_comb begin
        top    = '0;
        left   = '0;
        bottom = '0;
        right  = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            top[i*COORD_W +: COORD_W]    = top_q[i];
            left[i*COORD_W +: COORD_W]   = left_q[i];
            bottom[i*COORD_W +: COORD_W] = bottom_q[i];
            right[i*COORD_W +: COORD_W]  = right_q[i];
        end
    end

    assign num_hazards = count;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_hazard_collector.sv
// Self-checking bench for hazard_collector: table-driven frames, a box
// scoreboard queue, and hand-written hold, overflow and mid-frame reset sequences.
module tb_hazard_collector;

    localparam int CW    = 11;
    localparam int SL    = 16;
    localparam int FW    = SL * CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_keep, in_last;
    logic [CW-1:0] in_top, in_left, in_bottom, in_right;
    logic          frame_valid, frame_ready;
    logic [3:0]    num_hazards;
    logic [FW-1:0] top, left, bottom, right;
    logic          overflow;

    hazard_collector #(.COORD_W(CW), .SLOTS(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_keep(in_keep), .in_last(in_last),
        .in_top(in_top), .in_left(in_left), .in_bottom(in_bottom), .in_right(in_right),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .num_hazards(num_hazards),
        .top(top), .left(left), .bottom(bottom), .right(right),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] t, l, b, r;
    } box_t;

    typedef struct {
        bit            keep;
        bit            last;
        box_t          in;
        box_t          exp;
        int            hold;
    } vec_t;

    box_t   sb[$];
    box_t   m_box[SL];
    int     m_cnt;
    bit     m_ovf;
    int     checks = 0;
    int     errors = 0;
    vec_t   vecs[6];

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic box_t mk(input int t, input int l, input int b, input int r);
        box_t x;
        x.t = CW'(t); x.l = CW'(l); x.b = CW'(b); x.r = CW'(r);
        return x;
    endfunction

    task automatic model_clear();
        sb.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        for (int i = 0; i < SL; i++) m_box[i] = mk(0, 0, 0, 0);
    endtask

    task automatic chk_arrays(input string tag);
        logic [FW-1:0] et, el, eb, er;
        et = '0; el = '0; eb = '0; er = '0;
        for (int i = 0; i < SL; i++) begin
            et[i*CW +: CW] = m_box[i].t;
            el[i*CW +: CW] = m_box[i].l;
            eb[i*CW +: CW] = m_box[i].b;
            er[i*CW +: CW] = m_box[i].r;
        end
        chk({tag, ".top"},    top,    et);
        chk({tag, ".left"},   left,   el);
        chk({tag, ".bottom"}, bottom, eb);
        chk({tag, ".right"},  right,  er);
    endtask

    task automatic send(input bit keep, input bit last, input box_t b, input box_t e);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_keep = keep; in_last = last;
        in_top = b.t; in_left = b.l; in_bottom = b.b; in_right = b.r;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout actual=in_ready0 required=in_ready1");
        end else begin
            @(posedge clk);
            if (keep) begin
                if (m_cnt < SL - 1) begin
                    sb.push_back(e);
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            #1;
        end
        in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        int n;
        n = 0;
        while (!frame_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".frame_valid"}, FW'(frame_valid), FW'(1));
        chk({tag, ".in_ready"},    FW'(in_ready),    FW'(0));
        chk({tag, ".num_hazards"}, FW'(num_hazards), FW'(m_cnt));
        chk({tag, ".overflow"},    FW'(overflow),    FW'(m_ovf));
        for (int i = 0; i < SL; i++) m_box[i] = mk(0, 0, 0, 0);
        for (int i = 0; i < m_cnt; i++) m_box[i] = sb.pop_front();
        chk_arrays(tag);
    endtask

    task automatic hold_cycles(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_keep = 1'b1; in_last = 1'b1;
            in_top = 11'd99; in_left = 11'd99; in_bottom = 11'd100; in_right = 11'd100;
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, FW'(frame_valid), FW'(1));
            chk({tag, ".hold_ready"}, FW'(in_ready),    FW'(0));
            chk({tag, ".hold_num"},   FW'(num_hazards), FW'(m_cnt));
            chk_arrays({tag, ".hold"});
        end
        in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
    endtask

    task automatic release_frame(input string tag);
        @(negedge clk);
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        model_clear();
        chk({tag, ".rel_valid"}, FW'(frame_valid), FW'(0));
        chk({tag, ".rel_ready"}, FW'(in_ready),    FW'(1));
        chk({tag, ".rel_num"},   FW'(num_hazards), FW'(0));
        chk({tag, ".rel_ovf"},   FW'(overflow),    FW'(0));
        chk_arrays({tag, ".rel"});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".in_ready"},    FW'(in_ready),    FW'(1));
        chk({tag, ".frame_valid"}, FW'(frame_valid), FW'(0));
        chk({tag, ".num_hazards"}, FW'(num_hazards), FW'(0));
        chk({tag, ".overflow"},    FW'(overflow),    FW'(0));
        chk_arrays(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
        in_top = '0; in_left = '0; in_bottom = '0; in_right = '0;
        frame_ready = 1'b0;
        model_clear();

        vecs[0] = '{keep: 1, last: 0, in: mk(1, 1, 5, 2),    exp: mk(1, 1, 5, 2),    hold: 0};
        vecs[1] = '{keep: 1, last: 1, in: mk(20, 5, 24, 8),  exp: mk(20, 5, 24, 8),  hold: 5};
        vecs[2] = '{keep: 1, last: 0, in: mk(24, 8, 20, 5),  exp: mk(20, 5, 24, 8),  hold: 0};
        vecs[3] = '{keep: 0, last: 0, in: mk(7, 7, 7, 7),    exp: mk(0, 0, 0, 0),    hold: 0};
        vecs[4] = '{keep: 1, last: 1, in: mk(3, 9, 0, 2),    exp: mk(0, 2, 3, 9),    hold: 0};
        vecs[5] = '{keep: 0, last: 1, in: mk(5, 5, 6, 6),    exp: mk(0, 0, 0, 0),    hold: 1};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk) rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            send(vecs[v].keep, vecs[v].last, vecs[v].in, vecs[v].exp);
            if (vecs[v].last) begin
                check_frame($sformatf("vec%0d", v));
                if (vecs[v].hold > 0) hold_cycles($sformatf("vec%0d", v), vecs[v].hold);
                release_frame($sformatf("vec%0d", v));
            end
        end

        for (int i = 0; i < 17; i++)
            send(1'b1, i == 16, mk(i, i, i + 1, i + 1), mk(i, i, i + 1, i + 1));
        check_frame("ovf");
        chk("ovf.slot14_top", FW'(top[14*CW +: CW]), FW'(14));
        chk("ovf.slot15_top", FW'(top[15*CW +: CW]), FW'(0));
        release_frame("ovf");
        send(1'b1, 1'b1, mk(2, 3, 4, 5), mk(2, 3, 4, 5));
        check_frame("after_ovf");
        release_frame("after_ovf");

        for (int i = 0; i < 3; i++)
            send(1'b1, 1'b0, mk(10 + i, 10, 12 + i, 12), mk(10 + i, 10, 12 + i, 12));
        @(negedge clk) rst_n = 1'b0;
        model_clear();
        #1;
        chk_reset_state("midreset");
        @(negedge clk) rst_n = 1'b1;
        send(1'b1, 1'b1, mk(30, 31, 32, 33), mk(30, 31, 32, 33));
        check_frame("midreset_frame");
        release_frame("midreset_frame");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
